axi_copy_master: RTL

AXI_COPY_MASTER -- requirements
Module: axi_copy_master

---
 rtl/axi_pkg.sv | 42 ++++
 rtl/axi_line_buf.sv | 27 ++
 rtl/axi_copy_master.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// Shared AXI constants, copy-engine state encoding and the burst sizing helper.
package axi_pkg;

  localparam int unsigned ID_W   = 16;
  localparam int unsigned ADDR_W = 64;
  localparam int unsigned LEN_W  = 8;
  localparam int unsigned DATA_W = 512;
  localparam int unsigned STRB_W = 64;

  localparam logic [2:0] AXSIZE_64B  = 3'd6;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam int unsigned LINE_BYTES = 64;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR   = 3'd1,
    S_R    = 3'd2,
    S_AW   = 3'd3,
    S_W    = 3'd4,
    S_B    = 3'd5,
    S_DONE = 3'd6
  } copy_state_e;

  // Largest burst that fits the remaining count, the burst cap and both 4 KB pages.
  function automatic logic [6:0] calc_beats(input logic [31:0] remaining,
                                            input logic [5:0]  src_blk,
                                            input logic [5:0]  dst_blk,
                                            input logic [31:0] max_burst);
    logic [31:0] beats;
    logic [31:0] src_room;
    logic [31:0] dst_room;
    src_room = 32'd64 - {26'd0, src_blk};
    dst_room = 32'd64 - {26'd0, dst_blk};
    beats    = max_burst;
    if (src_room < beats) beats = src_room;
    if (dst_room < beats) beats = dst_room;
    if (remaining < beats) beats = remaining;
    return 7'(beats);
  endfunction

endpackage

// File: rtl/axi_line_buf.sv
// Burst staging buffer: one line per beat, written from R, read asynchronously by W.
module axi_line_buf
  import axi_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned IDX_W = 4
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Line storage; contents need no reset since every beat is written before it is read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/axi_copy_master.sv
// Line-granular AXI memory copy engine: one read burst into a local buffer, then
// one write burst out of it, repeated until all lines are moved.
module axi_copy_master
  import axi_pkg::*;
#(
  parameter int unsigned     MAX_BURST = 16,
  parameter logic [ID_W-1:0] AXI_ID    = 16'h0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [63:0]       src_addr,
  input  logic [63:0]       dst_addr,
  input  logic [31:0]       num_lines,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [31:0]       lines_done,
  output logic [ID_W-1:0]   arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [LEN_W-1:0]  arlen,
  output logic [2:0]        arsize,
  output logic              arvalid,
  input  logic              arready,
  input  logic [ID_W-1:0]   rid,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready,
  output logic [ID_W-1:0]   awid,
  output logic [ADDR_W-1:0] awaddr,
  output logic [LEN_W-1:0]  awlen,
  output logic [2:0]        awsize,
  output logic              awvalid,
  input  logic              awready,
  output logic [ID_W-1:0]   wid,
  output logic [DATA_W-1:0] wdata,
  output logic [STRB_W-1:0] wstrb,
  output logic              wlast,
  output logic              wvalid,
  input  logic              wready,
  input  logic [ID_W-1:0]   bid,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready
);

  localparam int unsigned IDX_W       = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [31:0] MAX_BURST_W = 32'(MAX_BURST);

  copy_state_e state_q, state_d;
  logic [63:0] src_q, src_d;
  logic [63:0] dst_q, dst_d;
  logic [31:0] rem_q, rem_d;
  logic [6:0]  beats_q, beats_d;
  logic [6:0]  idx_q, idx_d;
  logic        error_q, error_d;
  logic [31:0] lines_done_q, lines_done_d;

  logic        last_beat_s;
  logic        buf_wr_en_s;
  logic [DATA_W-1:0] buf_rd_data_s;
  logic        unused_inputs_s;

  assign last_beat_s     = (idx_q == (beats_q - 7'd1));
  assign buf_wr_en_s     = (state_q == S_R) && rvalid;
  assign unused_inputs_s = ^{rid, bid, src_addr[5:0], dst_addr[5:0]};

  axi_line_buf #(
    .DEPTH (MAX_BURST),
    .IDX_W (IDX_W)
  ) u_line_buf (
    .clk     (clk),
    .wr_en   (buf_wr_en_s),
    .wr_idx  (idx_q[IDX_W-1:0]),
    .wr_data (rdata),
    .rd_idx  (idx_q[IDX_W-1:0]),
    .rd_data (buf_rd_data_s)
  );

  // Next-state and datapath update for the copy sequencer.
  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    dst_d        = dst_q;
    rem_d        = rem_q;
    beats_d      = beats_q;
    idx_d        = idx_q;
    error_d      = error_q;
    lines_done_d = lines_done_q;
    case (state_q)
      S_IDLE: begin
        if (start_valid) begin
          src_d        = {src_addr[63:6], 6'd0};
          dst_d        = {dst_addr[63:6], 6'd0};
          rem_d        = num_lines;
          error_d      = 1'b0;
          lines_done_d = 32'd0;
          idx_d        = 7'd0;
          beats_d      = calc_beats(num_lines, src_addr[11:6], dst_addr[11:6], MAX_BURST_W);
          if (num_lines == 32'd0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_AR;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_AR: begin
        if (arready) state_d = S_R;
        else         state_d = S_AR;
      end
      S_R: begin
        if (rvalid) begin
          // Protocol violations are recorded but the beat count alone drives progress.
          if ((rresp != RESP_OKAY) || (rlast != last_beat_s)) error_d = 1'b1;
          else                                                error_d = error_q;
          if (last_beat_s) begin
            idx_d   = 7'd0;
            state_d = S_AW;
          end else begin
            idx_d   = idx_q + 7'd1;
            state_d = S_R;
          end
        end else begin
          state_d = S_R;
        end
      end
      S_AW: begin
        if (awready) state_d = S_W;
        else         state_d = S_AW;
      end
      S_W: begin
        if (wready) begin
          if (last_beat_s) begin
            idx_d   = 7'd0;
            state_d = S_B;
          end else begin
            idx_d   = idx_q + 7'd1;
            state_d = S_W;
          end
        end else begin
          state_d = S_W;
        end
      end
      S_B: begin
        if (bvalid) begin
          if (bresp != RESP_OKAY) error_d = 1'b1;
          else                    error_d = error_q;
          src_d        = src_q + {51'd0, beats_q, 6'd0};
          dst_d        = dst_q + {51'd0, beats_q, 6'd0};
          rem_d        = rem_q - {25'd0, beats_q};
          lines_done_d = lines_done_q + {25'd0, beats_q};
          beats_d      = calc_beats(rem_d, src_d[11:6], dst_d[11:6], MAX_BURST_W);
          if (rem_d == 32'd0) state_d = S_DONE;
          else                state_d = S_AR;
        end else begin
          state_d = S_B;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer registers; reset abandons any transfer in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      src_q        <= 64'd0;
      dst_q        <= 64'd0;
      rem_q        <= 32'd0;
      beats_q      <= 7'd0;
      idx_q        <= 7'd0;
      error_q      <= 1'b0;
      lines_done_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      rem_q        <= rem_d;
      beats_q      <= beats_d;
      idx_q        <= idx_d;
      error_q      <= error_d;
      lines_done_q <= lines_done_d;
    end
  end

  assign start_ready = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign error       = error_q;
  assign lines_done  = lines_done_q;

  assign arid    = AXI_ID;
  assign araddr  = src_q;
  assign arlen   = {1'b0, beats_q - 7'd1};
  assign arsize  = AXSIZE_64B;
  assign arvalid = (state_q == S_AR);
  assign rready  = (state_q == S_R);

  assign awid    = AXI_ID;
  assign awaddr  = dst_q;
  assign awlen   = {1'b0, beats_q - 7'd1};
  assign awsize  = AXSIZE_64B;
  assign awvalid = (state_q == S_AW);

  assign wid     = AXI_ID;
  assign wdata   = buf_rd_data_s;
  assign wstrb   = {STRB_W{1'b1}};
  assign wlast   = (state_q == S_W) && last_beat_s;
  assign wvalid  = (state_q == S_W);
  assign bready  = (state_q == S_B);

endmodule
